// File: rtl/mcu_to_raster.sv
// mcu_to_raster: 4:2:0 MCU rows in, raster YUV pixels out, via a ping-pong 16-line stripe store.
// Optional MCU_RASTER_CHROMA_REPLICATE_EN: replicate U/V onto every pixel (4:4:4 output).
module mcu_to_raster #(
    parameter int SENSOR_X_SIZE = 720,
    parameter int SENSOR_Y_SIZE = 720,
    parameter int DW = 8,
    parameter logic [DW-1:0] JPEG_BIAS = DW'(128),
    localparam int XW = $clog2(SENSOR_X_SIZE),
    localparam int YW = $clog2(SENSOR_Y_SIZE)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0][DW-1:0]    mcu_in,
    input  logic                  mcu_in_valid,
    output logic                  mcu_in_hold,
    input  logic [2:0]            mcu_in_cnt,
    output logic [2:0][DW-1:0]    yuv_out,
    output logic [2:0]            yuv_out_valid,
    input  logic                  yuv_out_hold,
    output logic [XW-1:0]         yuv_out_pixel_count,
    output logic [YW-1:0]         yuv_out_line_count,
    output logic                  eof_out,
    output logic                  sync_err,
    input  logic [XW-1:0]         x_size_m1,
    input  logic [YW-1:0]         y_size_m1
);

    localparam int BXW = XW - 4;
    localparam int BYW = YW - 4;
    localparam int YWA = $clog2((SENSOR_X_SIZE + 7) / 8);
    localparam int CWA = $clog2((SENSOR_X_SIZE + 15) / 16);
    localparam int YAW = YWA + 5;
    localparam int CAW = CWA + 4;

    typedef logic [7:0][DW-1:0] word_t;

    // Each word holds one 8-sample MCU row; address = {bank, stripe row, word column}
    word_t y_mem [2**YAW];
    word_t u_mem [2**CAW];
    word_t v_mem [2**CAW];

    logic [2:0]      row_q, mcu_q;
    logic [BXW-1:0]  bx_q;
    logic            wr_bank_q;
    logic [1:0]      full_q, full_d;
    logic            sync_err_q;

    logic [XW-1:0]   iss_x_q;
    logic [3:0]      iss_line_q;
    logic [BYW-1:0]  iss_by_q;
    logic            iss_bank_q;

    logic            s1_v_q, s1_eof_q, s1_rel_q, s1_bank_q;
    logic [XW-1:0]   s1_x_q;
    logic [YW-1:0]   s1_y_q;
    logic [2:0]      s1_ysel_q, s1_csel_q;
`ifndef MCU_RASTER_CHROMA_REPLICATE_EN
    logic            s1_cv_q;
`endif
    word_t           y_rd_q, u_rd_q, v_rd_q;

    logic [2:0][DW-1:0] yuv_out_q;
    logic [2:0]      valid_q;
    logic [XW-1:0]   pix_q;
    logic [YW-1:0]   line_q;
    logic            eof_q, s2_rel_q, s2_bank_q;

    word_t           wdata;
    logic            accept, fill, bx_last;
    logic [YAW-1:0]  y_waddr, y_raddr;
    logic [CAW-1:0]  c_waddr, c_raddr;
    logic [YW-1:0]   rem;
    logic [3:0]      lines_m1;
    logic            last_x, last_line, last_by;
    logic            s2_free, s1_free, issue, rel;

    assign mcu_in_hold = full_q[wr_bank_q];
    assign accept      = mcu_in_valid & ~mcu_in_hold;
    assign bx_last     = (bx_q == x_size_m1[XW-1:4]);
    assign fill        = accept & (row_q == 3'd7) & (mcu_q == 3'd5) & bx_last;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < 8; i++) wdata[i] = mcu_in[i] + JPEG_BIAS;
    end

    assign y_waddr = {wr_bank_q, mcu_q[1], row_q, YWA'({bx_q, mcu_q[0]})};
    assign c_waddr = {wr_bank_q, row_q, CWA'(bx_q)};
    assign y_raddr = {iss_bank_q, iss_line_q, YWA'(iss_x_q >> 3)};
    assign c_raddr = {iss_bank_q, iss_line_q[3:1], CWA'(iss_x_q >> 4)};

    // Last stripe of the frame may be shorter than 16 lines
    assign rem       = y_size_m1 - {iss_by_q, 4'b0000};
    assign lines_m1  = (rem >= YW'(15)) ? 4'd15 : rem[3:0];
    assign last_x    = (iss_x_q == x_size_m1);
    assign last_line = (iss_line_q == lines_m1);
    assign last_by   = (iss_by_q == y_size_m1[YW-1:4]);

    assign s2_free = ~valid_q[0] | ~yuv_out_hold;
    assign s1_free = ~s1_v_q | s2_free;
    assign issue   = full_q[iss_bank_q] & s1_free;
    assign rel     = valid_q[0] & ~yuv_out_hold & s2_rel_q;

    always_comb begin
        full_d = full_q;
        if (rel)  full_d[s2_bank_q] = 1'b0;
        if (fill) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q      <= '0;
            mcu_q      <= '0;
            bx_q       <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                if (mcu_in_cnt != row_q) sync_err_q <= 1'b1;
                row_q <= row_q + 3'd1;
                if (row_q == 3'd7) begin
                    mcu_q <= (mcu_q == 3'd5) ? 3'd0 : mcu_q + 3'd1;
                    if (mcu_q == 3'd5) begin
                        bx_q <= bx_last ? '0 : bx_q + BXW'(1);
                        if (bx_last) wr_bank_q <= ~wr_bank_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !mcu_q[2])         y_mem[y_waddr] <= wdata;
        if (accept && mcu_q == 3'd4)     u_mem[c_waddr] <= wdata;
        if (accept && mcu_q == 3'd5)     v_mem[c_waddr] <= wdata;
        if (issue) begin
            y_rd_q <= y_mem[y_raddr];
            u_rd_q <= u_mem[c_raddr];
            v_rd_q <= v_mem[c_raddr];
        end
    end

    // Issue side runs ahead into the next bank while the previous one drains
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iss_x_q    <= '0;
            iss_line_q <= '0;
            iss_by_q   <= '0;
            iss_bank_q <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_eof_q   <= 1'b0;
            s1_rel_q   <= 1'b0;
            s1_bank_q  <= 1'b0;
            s1_ysel_q  <= '0;
            s1_csel_q  <= '0;
`ifndef MCU_RASTER_CHROMA_REPLICATE_EN
            s1_cv_q    <= 1'b0;
`endif
        end else begin
            if (issue) begin
                if (last_x) begin
                    iss_x_q <= '0;
                    if (last_line) begin
                        iss_line_q <= '0;
                        iss_bank_q <= ~iss_bank_q;
                        iss_by_q   <= last_by ? '0 : iss_by_q + BYW'(1);
                    end else begin
                        iss_line_q <= iss_line_q + 4'd1;
                    end
                end else begin
                    iss_x_q <= iss_x_q + XW'(1);
                end
            end
            if (s1_free) begin
                s1_v_q <= issue;
                if (issue) begin
                    s1_x_q    <= iss_x_q;
                    s1_y_q    <= {iss_by_q, iss_line_q};
                    s1_eof_q  <= last_x & last_line & last_by;
                    s1_rel_q  <= last_x & last_line;
                    s1_bank_q <= iss_bank_q;
                    s1_ysel_q <= iss_x_q[2:0];
                    s1_csel_q <= iss_x_q[3:1];
`ifndef MCU_RASTER_CHROMA_REPLICATE_EN
                    s1_cv_q   <= ~iss_x_q[0] & ~iss_line_q[0];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            yuv_out_q <= '0;
            valid_q   <= '0;
            pix_q     <= '0;
            line_q    <= '0;
            eof_q     <= 1'b0;
            s2_rel_q  <= 1'b0;
            s2_bank_q <= 1'b0;
        end else if (s2_free) begin
            if (s1_v_q) begin
                yuv_out_q[0] <= y_rd_q[s1_ysel_q];
`ifdef MCU_RASTER_CHROMA_REPLICATE_EN
                yuv_out_q[1] <= u_rd_q[s1_csel_q];
                yuv_out_q[2] <= v_rd_q[s1_csel_q];
                valid_q      <= 3'b111;
`else
                yuv_out_q[1] <= s1_cv_q ? u_rd_q[s1_csel_q] : '0;
                yuv_out_q[2] <= s1_cv_q ? v_rd_q[s1_csel_q] : '0;
                valid_q      <= s1_cv_q ? 3'b111 : 3'b001;
`endif
                pix_q     <= s1_x_q;
                line_q    <= s1_y_q;
                eof_q     <= s1_eof_q;
                s2_rel_q  <= s1_rel_q;
                s2_bank_q <= s1_bank_q;
            end else begin
                valid_q  <= '0;
                eof_q    <= 1'b0;
                s2_rel_q <= 1'b0;
            end
        end
    end

    assign yuv_out             = yuv_out_q;
    assign yuv_out_valid       = valid_q;
    assign yuv_out_pixel_count = pix_q;
    assign yuv_out_line_count  = line_q;
    assign eof_out             = eof_q;
    assign sync_err            = sync_err_q;

endmodule
